// File: rtl/seq_detector_1011.sv
// Moore detector for the serial pattern 1011 (overlap allowed), with sample enable,
// synchronous clear, saturating detection counter and a four-bit input history.
module seq_detector_1011 (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       en,
  input  logic       clr,
  output logic       detect,
  output logic [7:0] count,
  output logic [2:0] state,
  output logic [3:0] hist
);

  // Each code names the longest prefix of 1011 matched so far.
  typedef enum logic [2:0] {
    S0 = 3'b000,
    S1 = 3'b001,
    S2 = 3'b010,
    S3 = 3'b011,
    S4 = 3'b100
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] count_q, count_d;
  logic [3:0] hist_q,  hist_d;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path through
    // the block leaves a signal unassigned and no latch is inferred.
    state_d = state_q;
    count_d = count_q;
    hist_d  = hist_q;

    if (clr) begin
      state_d = S0;
      count_d = '0;
      hist_d  = '0;
    end else if (en) begin
      hist_d = {hist_q[2:0], din};
      case (state_q)
        S0:      state_d = din ? S1 : S0;
        S1:      state_d = din ? S1 : S2;
        S2:      state_d = din ? S3 : S0;
        S3:      state_d = din ? S4 : S2;
        S4:      state_d = din ? S1 : S2;
        default: state_d = S0;  // unreachable codes recover to idle
      endcase
      if (state_d == S4 && count_q != 8'hFF) begin
        count_d = count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S0;
      count_q <= '0;
      hist_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples the pre-edge values, independent of statement order.
      state_q <= state_d;
      count_q <= count_d;
      hist_q  <= hist_d;
    end
  end

  // Detect decodes registered state only, so din never reaches it combinationally.
  assign detect = (state_q == S4);
  assign count  = count_q;
  assign state  = state_q;
  assign hist   = hist_q;

endmodule

// File: doc/seq_detector_1011.md
SEQ_DETECTOR_1011 -- requirements
Module: seq_detector_1011

Interface
REQ-001 SHALL provide: clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL provide: rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL provide: din  input  1  serial bit stream, driven by the q output of the upstream D flip-flop stage.
REQ-004 SHALL provide: en  input  1  sample enable; din is consumed only on edges where en=1.
REQ-005 SHALL provide: clr  input  1  synchronous clear of FSM, counter and history.
REQ-006 SHALL provide: detect  output  1  Moore flag, 1 while FSM is in S4.
REQ-007 SHALL provide: count  output  8  number of detections since reset/clear, saturating.
REQ-008 SHALL provide: state  output  3  current FSM encoding, for debug.
REQ-009 SHALL provide: hist  output  4  last four consumed bits, newest in hist[0].

Function
REQ-010 SHALL implement a Moore FSM detecting the pattern 1011 (first bit received first), with overlap allowed.
REQ-011 SHALL use state encodings S0=000 (none), S1=001 ("1"), S2=010 ("10"), S3=011 ("101"), S4=100 ("1011").
REQ-012 SHALL apply transitions (din=0 / din=1): S0->S0/S1; S1->S2/S1; S2->S0/S3; S3->S2/S4; S4->S2/S1.
REQ-013 SHALL force codes 101-111 to S0 on the next enabled edge (illegal-state recovery); detect=0 in those codes.
REQ-014 SHALL drive detect=1 exactly when state=S4: latency of one cycle from the edge that consumes the final 1.
REQ-015 SHALL increment count by 1 on each enabled edge whose next state is S4.
REQ-016 SHALL saturate count at 255 (8'hFF); no wrap to 0.
REQ-017 SHALL update hist as {hist[2:0], din} on every enabled edge.
REQ-018 SHALL hold state, count and hist unchanged on edges where en=0; detect follows the held state.
REQ-019 SHALL, when clr=1 on an edge, set state=S0, count=0 and hist=0, regardless of en and din.
REQ-020 SHALL give clr priority over en; din is not consumed on a clr edge.
REQ-021 SHALL contain no combinational path from din to detect.

Reset
REQ-022 SHALL, while rst=0, immediately and independently of clk, force state=S0, detect=0, count=8'h00 and hist=4'h0.
REQ-023 SHALL abandon any partial match when rst asserts mid-pattern; matching restarts from S0 after release.
REQ-024 SHALL resume normal operation on the first rising clk edge after rst returns to 1.

Verification
REQ-025 SHALL pass: rst=0 pulse mid-cycle, then check outputs -> state=000, detect=0, count=0, hist=0 before the next clk edge.
REQ-026 SHALL pass: en=1, din=1,0,1,1,0,1,1 -> detect high after the 4th and 7th edges, count=2, hist=4'b1011.
REQ-027 SHALL pass: din=1,0,1 followed by en=0 for 3 cycles, then din=1 with en=1 -> state held at 011 during the stall; detect=1 after resume; count=1.
REQ-028 SHALL pass: din=1,0,1, then clr=1 with din=1 -> state=000, count=0, hist=0; detect stays 0.
REQ-029 SHALL pass: feed 1011 repeated 300 times -> count stops at 255 and stays at 255; detect still pulses once per match.
REQ-030 SHALL pass: din=1,0,1 then rst=0 then din=1 -> no detect; count=0.
